window_sequencer: RTL

- Sequences the pixel line buffer (block RAM) for 3x3 neighbourhood generation.
- Accepts a raster pixel stream under a valid/ready handshake and writes each pixel into a 3-row circular buffer.
- Reads back the two pixels above it in the same column, and strobes the steering/window registers so they shift in one column per pixel.
- Replaces free-running write/read clock gating with a single-clock scheduled controller.

---
 rtl/window_pkg.sv | 22 ++
 rtl/window_sequencer_line_base_rotator.sv | 34 +++
 rtl/window_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/window_pkg.sv
// Shared types and constants for the 3x3 window line-buffer sequencer.
// State encoding, BRAM read latency and counter-width helper.
package window_pkg;

   localparam int RD_LAT = 1;

   // The read states are spaced by the BRAM read latency, so the tap
   // strobe in RD_UP1 lines up with the data requested in RD_UP2.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEPT = 3'd1,
      S_RD_UP2 = 3'd2,
      S_RD_UP1 = 3'(2 + RD_LAT),
      S_SHIFT  = 3'(3 + RD_LAT),
      S_DONE   = 3'(4 + RD_LAT)
   } state_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/window_sequencer_line_base_rotator.sv
// Holds the three row base addresses of the circular line buffer.
// Rotates them at each row end so the oldest row slot is rewritten.
module line_base_rotator
   import window_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int ADDR_W = 11
) (
   input  logic              mainClk,
   input  logic              reset,
   input  logic              init,
   input  logic              row_end,
   output logic [ADDR_W-1:0] base_cur,
   output logic [ADDR_W-1:0] base_up1,
   output logic [ADDR_W-1:0] base_up2
);

   localparam logic [ADDR_W-1:0] UP1_INIT = ADDR_W'(2 * IMG_W);
   localparam logic [ADDR_W-1:0] UP2_INIT = ADDR_W'(IMG_W);

   // Load the frame-start layout, else rotate slots at each row end.
   always_ff @(posedge mainClk) begin
      if (reset || init) begin
         base_cur <= '0;
         base_up1 <= UP1_INIT;
         base_up2 <= UP2_INIT;
      end else if (row_end) begin
         base_cur <= base_up2;
         base_up2 <= base_up1;
         base_up1 <= base_cur;
      end
   end

endmodule

// File: rtl/window_sequencer.sv
// Single-clock scheduler for the 3-row pixel line buffer.
// Writes each pixel, reads the two above it, then shifts the window.
module window_sequencer
   import window_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 11,
   parameter int CW     = cnt_w(IMG_W),
   parameter int RW     = cnt_w(IMG_H)
) (
   input  logic              mainClk,
   input  logic              reset,
   input  logic              start,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              bram_wr_en,
   output logic [ADDR_W-1:0] bram_wr_addr,
   output logic              bram_rd_en,
   output logic [ADDR_W-1:0] bram_rd_addr,
   output logic              tap_top_load,
   output logic              tap_mid_load,
   output logic              win_shift,
   output logic              win_valid,
   output logic [RW-1:0]     center_row,
   output logic [CW-1:0]     center_col,
   output logic              busy,
   output logic              frame_done
);

   state_t            state, state_nxt;
   logic [RW-1:0]     r;
   logic [CW-1:0]     c;
   logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
   logic [ADDR_W-1:0] base_cur, base_up1, base_up2;
   logic [ADDR_W-1:0] col_off;
   logic              last_col, last_pix;
   logic              init, row_end;

   assign col_off  = ADDR_W'(c);
   assign last_col = (c == CW'(IMG_W - 1));
   assign last_pix = last_col && (r == RW'(IMG_H - 1));
   assign init     = (state == S_IDLE) && start;
   assign row_end  = (state == S_SHIFT) && last_col;

   line_base_rotator #(
      .IMG_W  (IMG_W),
      .ADDR_W (ADDR_W)
   ) u_rot (
      .mainClk  (mainClk),
      .reset    (reset),
      .init     (init),
      .row_end  (row_end),
      .base_cur (base_cur),
      .base_up1 (base_up1),
      .base_up2 (base_up2)
   );

   // State register.
   always_ff @(posedge mainClk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state and Moore strobes; write strobe gated by pix_valid.
   always_comb begin
      state_nxt    = state;
      pix_ready    = 1'b0;
      bram_wr_en   = 1'b0;
      bram_wr_addr = wr_addr_q;
      bram_rd_en   = 1'b0;
      bram_rd_addr = rd_addr_q;
      tap_top_load = 1'b0;
      tap_mid_load = 1'b0;
      win_shift    = 1'b0;
      win_valid    = 1'b0;
      busy         = 1'b1;
      frame_done   = 1'b0;
      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_ACCEPT;
         end
         S_ACCEPT: begin
            pix_ready = 1'b1;
            if (pix_valid) begin
               bram_wr_en   = 1'b1;
               bram_wr_addr = base_cur + col_off;
               state_nxt    = S_RD_UP2;
            end
         end
         S_RD_UP2: begin
            bram_rd_en   = 1'b1;
            bram_rd_addr = base_up2 + col_off;
            state_nxt    = S_RD_UP1;
         end
         S_RD_UP1: begin
            bram_rd_en   = 1'b1;
            bram_rd_addr = base_up1 + col_off;
            tap_top_load = 1'b1;
            state_nxt    = S_SHIFT;
         end
         S_SHIFT: begin
            tap_mid_load = 1'b1;
            win_shift    = 1'b1;
            win_valid    = (r >= RW'(2)) && (c >= CW'(2));
            state_nxt    = last_pix ? S_DONE : S_ACCEPT;
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Raster position, held addresses and window centre.
   always_ff @(posedge mainClk) begin
      if (reset) begin
         r          <= '0;
         c          <= '0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         center_row <= '0;
         center_col <= '0;
      end else begin
         wr_addr_q <= bram_wr_addr;
         rd_addr_q <= bram_rd_addr;
         if (init) begin
            r <= '0;
            c <= '0;
         end else if (state == S_SHIFT) begin
            if (last_col) begin
               c <= '0;
               r <= r + RW'(1);
            end else begin
               c <= c + CW'(1);
            end
         end
         if (state == S_RD_UP1) begin
            center_row <= r - RW'(1);
            center_col <= c - CW'(1);
         end
      end
   end

endmodule
